// File: rtl/ram_port_arb_pkg.sv
// Shared constants and helpers for the RAM port arbiter slice.
package ram_arb_pkg;

  localparam int MODE_TDM = 0;
  localparam int MODE_RR  = 1;

  // Width of a port index; callers keep n >= 2 so the result is never zero.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_port_arb_if.sv
// Requester-side and RAM-side signal bundle of the arbiter. The arbiter uses
// slave; the requesters together with the RAM instance form the master side.
interface ram_port_arb_if #(
  parameter int NPORTS = 2,
  parameter int AW     = 16,
  parameter int DW     = 8
);
  logic [NPORTS-1:0]    p_req;
  logic [NPORTS-1:0]    p_we;
  logic [NPORTS*AW-1:0] p_addr;
  logic [NPORTS*DW-1:0] p_wdata;
  logic [NPORTS-1:0]    p_ack;
  logic [NPORTS*DW-1:0] p_rdata;
  logic [AW-1:0]        ram_addr;
  logic                 ram_we;
  logic [DW-1:0]        ram_wdata;
  logic [DW-1:0]        ram_rdata;

  modport master (
    output p_req, p_we, p_addr, p_wdata, ram_rdata,
    input  p_ack, p_rdata, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  p_req, p_we, p_addr, p_wdata, ram_rdata,
    output p_ack, p_rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/ram_port_arb_rr_pick.sv
// Combinational picker: first set bit of elig scanning upward from ptr, wrapping.
module rr_pick #(
  parameter int NPORTS = 3,
  parameter int IW     = 2
) (
  input  logic [NPORTS-1:0] elig,
  input  logic [IW-1:0]     ptr,
  output logic [IW-1:0]     gnt_idx,
  output logic              gnt_vld
);
  localparam logic [IW:0] NP = (IW+1)'(NPORTS);

  // Scan from the farthest offset down so the nearest eligible port wins.
  always_comb begin
    logic [IW:0] sum;
    logic [IW-1:0] idx;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int off = NPORTS - 1; off >= 0; off--) begin
      sum     = {1'b0, ptr} + (IW+1)'(off);
      sum     = (sum >= NP) ? (sum - NP) : sum;
      idx     = sum[IW-1:0];
      gnt_idx = elig[idx] ? idx : gnt_idx;
      gnt_vld = gnt_vld | elig[idx];
    end
  end
endmodule

// File: rtl/ram_port_arb.sv
// Time-sliced arbiter sharing one single-port synchronous RAM between NPORTS
// requesters, using either fixed TDM slots or work-conserving round-robin.
module ram_port_arb
  import ram_arb_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int MODE   = MODE_TDM
) (
  input  logic           clk25,
  input  logic           rst,
  ram_port_arb_if.slave  bus
);
  localparam int IW = clog2(NPORTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NPORTS - 1);

  logic [NPORTS-1:0] busy_r;
  logic [NPORTS-1:0] elig_s;
  logic [NPORTS-1:0] grant_oh_s;
  logic              pend_rd_r;
  logic [IW-1:0]     cur_r;
  logic [IW-1:0]     cur_nxt_s;
  logic [IW-1:0]     pick_idx_s;
  logic              pick_vld_s;
  logic              grant_vld_s;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  assign elig_s = bus.p_req & ~busy_r;

  // cur_r is the TDM slot in MODE_TDM and the round-robin pointer in MODE_RR.
  if (MODE == MODE_RR) begin : g_rr
    rr_pick #(
      .NPORTS (NPORTS),
      .IW     (IW)
    ) u_pick (
      .elig    (elig_s),
      .ptr     (cur_r),
      .gnt_idx (pick_idx_s),
      .gnt_vld (pick_vld_s)
    );
  end else begin : g_tdm
    assign pick_idx_s = cur_r;
    assign pick_vld_s = elig_s[cur_r];
  end

  // No access may start while reset is held, even if a requester is active.
  assign grant_vld_s = pick_vld_s & ~rst;

  assign bus.ram_addr  = bus.p_addr[int'(pick_idx_s)*AW +: AW];
  assign bus.ram_wdata = bus.p_wdata[int'(pick_idx_s)*DW +: DW];
  assign bus.ram_we    = grant_vld_s & bus.p_we[pick_idx_s];

  // One-hot of the port issued this cycle.
  always_comb begin
    grant_oh_s             = '0;
    grant_oh_s[pick_idx_s] = grant_vld_s;
  end

  // Slot advances every cycle in TDM; pointer moves past the winner in RR.
  always_comb begin
    cur_nxt_s = cur_r;
    if (MODE == MODE_TDM) begin
      cur_nxt_s = next_idx(cur_r);
    end else if (grant_vld_s) begin
      cur_nxt_s = next_idx(pick_idx_s);
    end else begin
      cur_nxt_s = cur_r;
    end
  end

  // Issue pipeline: busy_r marks the port in its ack cycle, so it doubles as p_ack.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      busy_r    <= '0;
      pend_rd_r <= 1'b0;
      cur_r     <= '0;
    end else begin
      busy_r    <= grant_oh_s;
      pend_rd_r <= grant_vld_s & ~bus.p_we[pick_idx_s];
      cur_r     <= cur_nxt_s;
    end
  end

  assign bus.p_ack = busy_r;

  for (genvar k = 0; k < NPORTS; k++) begin : g_port
    logic          rd_ack_s;
    logic [DW-1:0] hold_r;

    assign rd_ack_s = busy_r[k] & pend_rd_r;

    // Read-data hold register, refreshed only at this port's read ack.
    always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
        hold_r <= '0;
      end else if (rd_ack_s) begin
        hold_r <= bus.ram_rdata;
      end
    end

    assign bus.p_rdata[k*DW +: DW] = rd_ack_s ? bus.ram_rdata : hold_r;
  end
endmodule
